// File: rtl/comprovador_comptador.sv
// comprovador_comptador: sequence checker for an enabled up-counter bus.
// Predicts each sample from the previous one, locks after LOCK_COUNT correct
// increments and then reports out-of-sequence values as errors.
// Optional build macro COMPROVADOR_ZERO_RESYNC_EN: when defined, a value of
// zero seen while locked (and not predicted) is taken as a counter reset
// instead of an error.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | first sample after reset, nothing to compare against yet
//   S_SYNC   | counting consecutive correct increments towards lock
//   S_LOCKED | locked on; any mismatch is reported as an error

module comprovador_comptador #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_in,
    input  logic [WIDTH-1:0]     cnt_in,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_LOCKED
    } state_t;

    localparam logic [7:0]           LOCK_TARGET = 8'(LOCK_COUNT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

    state_t               state, state_nxt;
    logic [7:0]           good_cnt, good_cnt_nxt;
    logic [WIDTH-1:0]     prev_cnt;
    logic                 prev_en;
    logic [WIDTH-1:0]     pred;
    logic                 match;
    logic                 zero_resync;
    logic                 err_hit;
    logic                 locked_nxt;
    logic                 err_sticky_nxt;
    logic [ERR_CNT_W-1:0] err_count_nxt;

    assign pred  = prev_en ? prev_cnt + WIDTH'(1) : prev_cnt;
    assign match = (cnt_in == pred);

`ifdef COMPROVADOR_ZERO_RESYNC_EN
    assign zero_resync = (cnt_in == '0) && (pred != '0);
`else
    assign zero_resync = 1'b0;
`endif

    // Next-state, lock tracking and error bookkeeping for the current sample.
    always_comb begin
        state_nxt      = state;
        good_cnt_nxt   = good_cnt;
        locked_nxt     = locked;
        err_hit        = 1'b0;
        err_sticky_nxt = err_sticky;
        err_count_nxt  = err_count;

        case (state)
            S_IDLE: begin
                state_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (!match) begin
                    good_cnt_nxt = 8'd0;
                end else if (prev_en) begin
                    good_cnt_nxt = good_cnt + 8'd1;
                    if (good_cnt + 8'd1 == LOCK_TARGET) begin
                        state_nxt  = S_LOCKED;
                        locked_nxt = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (!match && !zero_resync) begin
                    err_hit      = 1'b1;
                    locked_nxt   = 1'b0;
                    good_cnt_nxt = 8'd0;
                    state_nxt    = S_SYNC;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // A new error beats a simultaneous clear: the count restarts at one.
        if (err_hit) begin
            err_sticky_nxt = 1'b1;
            if (clr_err)
                err_count_nxt = ERR_CNT_W'(1);
            else if (err_count != ERR_MAX)
                err_count_nxt = err_count + ERR_CNT_W'(1);
        end else if (clr_err) begin
            err_sticky_nxt = 1'b0;
            err_count_nxt  = '0;
        end
    end

    // State, history and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            good_cnt   <= 8'd0;
            prev_cnt   <= '0;
            prev_en    <= 1'b0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            expected   <= '0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_cnt_nxt;
            prev_cnt   <= cnt_in;
            prev_en    <= en_in;
            locked     <= locked_nxt;
            err_pulse  <= err_hit;
            err_sticky <= err_sticky_nxt;
            err_count  <= err_count_nxt;
            expected   <= en_in ? cnt_in + WIDTH'(1) : cnt_in;
        end
    end

endmodule
